id_decode_sb: RTL

//  Parametrised successor of the instruction-decode stage. Sits between IF and EX.

---
 rtl/id_pkg.sv | 55 +++++
 rtl/id_decode_sb_if.sv | 36 +++
 rtl/id_scoreboard.sv | 35 +++
 rtl/id_decode_sb.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared types for the decode stage: RV32I opcode map, immediate formats,
// stage occupancy states and the decoded-instruction bundle.
package id_pkg;

    localparam logic [6:0] LUI         = 7'b0110111;
    localparam logic [6:0] AUIPC       = 7'b0010111;
    localparam logic [6:0] JAL         = 7'b1101111;
    localparam logic [6:0] JALR        = 7'b1100111;
    localparam logic [6:0] BRANCH      = 7'b1100011;
    localparam logic [6:0] LOAD        = 7'b0000011;
    localparam logic [6:0] STORE       = 7'b0100011;
    localparam logic [6:0] IMM_REG_ALU = 7'b0010011;
    localparam logic [6:0] REG_REG_ALU = 7'b0110011;
    localparam logic [6:0] MISC_MEM    = 7'b0001111;
    localparam logic [6:0] SYSTEM      = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
    } fmt_t;

    typedef enum logic {
        EMPTY, HELD
    } id_state_t;

    typedef struct packed {
        logic        valid;
        logic        use1;
        logic        use2;
        logic        wr;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } dec_t;

    // Immediate bits live in instr[31:7]; bit 31 is always the sign.
    function automatic logic [31:0] imm_gen(
        input logic [31:7] i,
        input fmt_t        f
    );
        logic [31:0] r;
        unique case (f)
            FMT_I:   r = {{20{i[31]}}, i[31:20]};
            FMT_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
            FMT_B:   r = {{19{i[31]}}, i[31], i[7],
                          i[30:25], i[11:8], 1'b0};
            FMT_U:   r = {i[31:12], 12'b0};
            FMT_J:   r = {{11{i[31]}}, i[31], i[19:12],
                          i[20], i[30:21], 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/id_decode_sb_if.sv
// IF->ID and ID->EX handshake bundle; master is the decode stage,
// slave is the surrounding pipeline.
interface id_decode_sb_if #(
    parameter int BITSIZE = 32,
    parameter int NREGS   = 32
);
    localparam int REG_AW = $clog2(NREGS);

    logic               if_give;
    logic               if_get;
    logic [31:0]        if_instr;
    logic [BITSIZE-1:0] if_pc;

    logic               ex_get;
    logic               ex_give;
    logic [31:0]        ex_instr;
    logic [BITSIZE-1:0] ex_pc;
    logic [BITSIZE-1:0] ex_rs1;
    logic [BITSIZE-1:0] ex_rs2;
    logic [BITSIZE-1:0] ex_imm;
    logic [REG_AW-1:0]  ex_rd;
    logic               ex_wr;

    modport master (
        input  if_give, if_instr, if_pc, ex_get,
        output if_get, ex_give, ex_instr, ex_pc,
        output ex_rs1, ex_rs2, ex_imm, ex_rd, ex_wr
    );

    modport slave (
        output if_give, if_instr, if_pc, ex_get,
        input  if_get, ex_give, ex_instr, ex_pc,
        input  ex_rs1, ex_rs2, ex_imm, ex_rd, ex_wr
    );

endinterface

// File: rtl/id_scoreboard.sv
// Busy bit per architectural register; a write issued to EX marks rd
// busy until writeback retires it. x0 is never busy.
module id_scoreboard #(
    parameter  int NREGS  = 32,
    localparam int REG_AW = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              resetn_i,
    input  logic              set,
    input  logic [REG_AW-1:0] set_idx,
    input  logic              clr,
    input  logic [REG_AW-1:0] clr_idx,
    input  logic [REG_AW-1:0] rs1_idx,
    input  logic [REG_AW-1:0] rs2_idx,
    output logic              rs1_busy,
    output logic              rs2_busy
);

    logic [NREGS-1:0] busy;

    // Set is applied after clear so a same-index collision stays busy.
    always_ff @(posedge clk) begin
        if (!resetn_i) begin
            busy <= '0;
        end else begin
            if (clr) busy[clr_idx] <= 1'b0;
            if (set) busy[set_idx] <= 1'b1;
            busy[0] <= 1'b0;
        end
    end

    assign rs1_busy = busy[rs1_idx];
    assign rs2_busy = busy[rs2_idx];

endmodule

// File: rtl/id_decode_sb.sv
// Decode stage with RAW scoreboard between IF and EX.
// Define ID_ZICSR_EN to accept the SYSTEM opcode (CSR, ECALL, EBREAK).
module id_decode_sb
    import id_pkg::*;
#(
    parameter  int BITSIZE = 32,
    parameter  int NREGS   = 32,
    localparam int REG_AW  = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               resetn_i,
    input  logic               flush_i,
    output logic               inv_instr_o,
    id_decode_sb_if.master     bus,
    output logic [REG_AW-1:0]  ID_REG_rs1_o,
    output logic [REG_AW-1:0]  ID_REG_rs2_o,
    input  logic [BITSIZE-1:0] REG_ID_rs1_d_i,
    input  logic [BITSIZE-1:0] REG_ID_rs2_d_i,
    input  logic               WB_ID_valid_i,
    input  logic [REG_AW-1:0]  WB_ID_rd_i
);

    id_state_t          state;
    dec_t               held;
    dec_t               dec;
    logic [31:0]        instr_q;
    logic [BITSIZE-1:0] pc_q;

    logic [6:0] op;
    fmt_t       fmt;
    logic       rd_used;
    logic       bad_idx;

    logic rs1_busy;
    logic rs2_busy;
    logic hazard;
    logic give;
    logic get;
    logic ex_xfer;
    logic if_xfer;

    assign op = bus.if_instr[6:0];

    always_comb begin
        dec       = '0;
        fmt       = FMT_R;
        rd_used   = 1'b0;
        dec.valid = (bus.if_instr[1:0] == 2'b11);
        dec.rs1   = bus.if_instr[19:15];
        dec.rs2   = bus.if_instr[24:20];
        dec.rd    = bus.if_instr[11:7];
        unique case (1'b1)
            (op == LUI), (op == AUIPC): begin
                fmt     = FMT_U;
                rd_used = 1'b1;
            end
            (op == JAL): begin
                fmt     = FMT_J;
                rd_used = 1'b1;
            end
            (op == JALR), (op == LOAD), (op == IMM_REG_ALU): begin
                fmt      = FMT_I;
                dec.use1 = 1'b1;
                rd_used  = 1'b1;
            end
            (op == BRANCH): begin
                fmt      = FMT_B;
                dec.use1 = 1'b1;
                dec.use2 = 1'b1;
            end
            (op == STORE): begin
                fmt      = FMT_S;
                dec.use1 = 1'b1;
                dec.use2 = 1'b1;
            end
            (op == REG_REG_ALU): begin
                dec.use1 = 1'b1;
                dec.use2 = 1'b1;
                rd_used  = 1'b1;
            end
            (op == MISC_MEM): begin
                fmt = FMT_R;
            end
`ifdef ID_ZICSR_EN
            (op == SYSTEM): begin
                unique case (bus.if_instr[14:12])
                    3'b000: fmt = FMT_R;
                    3'b100: dec.valid = 1'b0;
                    3'b001, 3'b010, 3'b011: begin
                        fmt      = FMT_I;
                        dec.use1 = 1'b1;
                        rd_used  = 1'b1;
                    end
                    default: begin
                        fmt     = FMT_I;
                        rd_used = 1'b1;
                    end
                endcase
            end
`endif
            default: dec.valid = 1'b0;
        endcase

        dec.imm = imm_gen(bus.if_instr[31:7], fmt);
`ifdef ID_ZICSR_EN
        // CSRR*I carry a zero-extended uimm in the rs1 field.
        if (op == SYSTEM && bus.if_instr[14])
            dec.imm = {27'b0, bus.if_instr[19:15]};
`endif

        bad_idx = (dec.use1 && int'(dec.rs1) >= NREGS)
               || (dec.use2 && int'(dec.rs2) >= NREGS)
               || (rd_used && int'(dec.rd) >= NREGS);
        if (bad_idx) dec.valid = 1'b0;
        dec.wr = rd_used && (dec.rd != 5'd0);
    end

    id_scoreboard #(.NREGS(NREGS)) u_sb (
        .clk      (clk),
        .resetn_i (resetn_i),
        .set      (ex_xfer && held.wr),
        .set_idx  (held.rd[REG_AW-1:0]),
        .clr      (WB_ID_valid_i),
        .clr_idx  (WB_ID_rd_i),
        .rs1_idx  (held.rs1[REG_AW-1:0]),
        .rs2_idx  (held.rs2[REG_AW-1:0]),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy)
    );

    assign hazard = (held.use1 && rs1_busy)
                 || (held.use2 && rs2_busy);

    assign give = resetn_i && (state == HELD) && held.valid
               && !hazard && !flush_i;
    assign ex_xfer = give && bus.ex_get;
    assign get = resetn_i
              && ((state == EMPTY) || ex_xfer || flush_i);
    assign if_xfer = bus.if_give && get;

    assign inv_instr_o = resetn_i && (state == HELD) && !held.valid;

    always_ff @(posedge clk) begin
        if (!resetn_i) begin
            state   <= EMPTY;
            held    <= '0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (if_xfer) begin
            state   <= HELD;
            held    <= dec;
            instr_q <= bus.if_instr;
            pc_q    <= bus.if_pc;
        end else if (state == HELD
                     && (ex_xfer || flush_i || !held.valid)) begin
            state <= EMPTY;
        end
    end

    assign bus.if_get   = get;
    assign bus.ex_give  = give;
    assign bus.ex_instr = instr_q;
    assign bus.ex_pc    = pc_q;
    assign bus.ex_rs1   = held.use1 ? REG_ID_rs1_d_i : '0;
    assign bus.ex_rs2   = held.use2 ? REG_ID_rs2_d_i : '0;
    assign bus.ex_imm   = BITSIZE'($signed(held.imm));
    assign bus.ex_rd    = held.rd[REG_AW-1:0];
    assign bus.ex_wr    = held.wr;

    assign ID_REG_rs1_o = held.rs1[REG_AW-1:0];
    assign ID_REG_rs2_o = held.rs2[REG_AW-1:0];

endmodule
